// File: rtl/jacobi_pair_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler_pkg
// Shared constants for the parallel cyclic Jacobi eigen-solver, the sequencing
// FSM state type, and the packed upper-triangle address helper. The helper is
// shared by the pair scheduler and the V-update logic.
//
// Packed layout: row i of the upper triangle starts at
//   rb(i) = i*N - i*(i-1)/2
// and element (i,j), i<=j, lives at rb(i) + (j-i). For N=8 the triangle
// occupies 36 words, and the V matrix follows it at JACOBI_V_OFFSET.
// -----------------------------------------------------------------------------
package jacobi_pair_scheduler_pkg;

  localparam int JACOBI_N            = 8;
  localparam int JACOBI_LOG2_N       = 3;
  localparam int JACOBI_N_PAIRS      = JACOBI_N / 2;
  localparam int JACOBI_LOG2_N_PAIRS = 2;
  localparam int JACOBI_ADDR_WIDTH   = 7;
  localparam int JACOBI_V_OFFSET     = JACOBI_N * (JACOBI_N + 1) / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ROUND,
    ST_SWEEP_END,
    ST_DONE
  } jacobi_state_e;

  // Address of element (i,j) with i<=j in the packed upper triangle.
  function automatic logic [JACOBI_ADDR_WIDTH-1:0] jacobi_tri_addr(input int i, input int j);
    int row_base;
    row_base = i * JACOBI_N - (i * (i - 1)) / 2;
    return JACOBI_ADDR_WIDTH'(row_base + (j - i));
  endfunction

endpackage

// File: rtl/jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler
// Emits the round-robin (tournament) ordering of disjoint index pairs for the
// parallel cyclic Jacobi solver: N-1 rounds per sweep, N/2 pairs per round,
// each pair handed to the CORDIC rotation datapath over valid/ready together
// with the packed addresses of a_pp, a_qq and a_pq.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a solve (ignored while busy)
//   cfg_n_sweeps      sweep limit, captured on accepted start (0 acts as 1)
//   converged         early-exit flag, looked at only at the end of a sweep
//   pair_valid/ready  pair handshake toward the rotation datapath
//   pair_p, pair_q    pair indices, p<q
//   pair_slot         slot within the current round
//   addr_pp/qq/pq     packed upper-triangle addresses for the pair
//   round_done        datapath finished all rotations of the round
//   round_idx         current round, sweep_idx current sweep
//   busy, done        solve in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module jacobi_pair_scheduler
  import jacobi_pair_scheduler_pkg::*;
#(
  parameter int N            = JACOBI_N,
  parameter int LOG2_N       = JACOBI_LOG2_N,
  parameter int N_PAIRS      = JACOBI_N_PAIRS,
  parameter int LOG2_N_PAIRS = JACOBI_LOG2_N_PAIRS,
  parameter int ADDR_WIDTH   = JACOBI_ADDR_WIDTH,
  parameter int SWEEP_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SWEEP_W-1:0]      cfg_n_sweeps,
  input  logic                    converged,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic [LOG2_N-1:0]       pair_p,
  output logic [LOG2_N-1:0]       pair_q,
  output logic [LOG2_N_PAIRS-1:0] pair_slot,
  output logic [ADDR_WIDTH-1:0]   addr_pp,
  output logic [ADDR_WIDTH-1:0]   addr_qq,
  output logic [ADDR_WIDTH-1:0]   addr_pq,
  input  logic                    round_done,
  output logic [LOG2_N-1:0]       round_idx,
  output logic [SWEEP_W-1:0]      sweep_idx,
  output logic                    busy,
  output logic                    done
);

  jacobi_state_e r_state, w_state_nxt;

  // Tournament seating: slot k pairs seat k with seat N-1-k. Seat 0 is fixed,
  // the other seats rotate by one position each round.
  logic [LOG2_N-1:0]       r_pos [N];
  logic [LOG2_N_PAIRS-1:0] r_slot;
  logic [LOG2_N-1:0]       r_round;
  logic [SWEEP_W-1:0]      r_sweep;
  logic [SWEEP_W-1:0]      r_n_sweeps;

  logic              w_last_slot;
  logic              w_last_round;
  logic              w_finish;
  logic [LOG2_N-1:0] w_lo_seat;
  logic [LOG2_N-1:0] w_hi_seat;
  logic [LOG2_N-1:0] w_a;
  logic [LOG2_N-1:0] w_b;

  assign w_lo_seat    = LOG2_N'(r_slot);
  assign w_hi_seat    = LOG2_N'(N - 1) - LOG2_N'(r_slot);
  assign w_a          = r_pos[w_lo_seat];
  assign w_b          = r_pos[w_hi_seat];
  assign w_last_slot  = (r_slot == LOG2_N_PAIRS'(N_PAIRS - 1));
  assign w_last_round = (r_round == LOG2_N'(N - 2));
  assign w_finish     = converged || ((r_sweep + SWEEP_W'(1)) == r_n_sweeps);

  assign pair_p    = (w_a < w_b) ? w_a : w_b;
  assign pair_q    = (w_a < w_b) ? w_b : w_a;
  assign pair_slot = r_slot;
  assign round_idx = r_round;
  assign sweep_idx = r_sweep;

  assign addr_pp = ADDR_WIDTH'(jacobi_tri_addr(int'(pair_p), int'(pair_p)));
  assign addr_qq = ADDR_WIDTH'(jacobi_tri_addr(int'(pair_q), int'(pair_q)));
  assign addr_pq = ADDR_WIDTH'(jacobi_tri_addr(int'(pair_p), int'(pair_q)));

  always_comb begin
    w_state_nxt = r_state;
    pair_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        pair_valid = 1'b1;
        busy       = 1'b1;
        if (pair_ready && w_last_slot) w_state_nxt = ST_WAIT_ROUND;
      end
      ST_WAIT_ROUND: begin
        busy = 1'b1;
        if (round_done) w_state_nxt = w_last_round ? ST_SWEEP_END : ST_ISSUE;
      end
      ST_SWEEP_END: begin
        busy        = 1'b1;
        w_state_nxt = w_finish ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_round    <= '0;
      r_sweep    <= '0;
      r_n_sweeps <= SWEEP_W'(1);
      for (int k = 0; k < N; k++) r_pos[k] <= LOG2_N'(k);
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n_sweeps <= (cfg_n_sweeps == '0) ? SWEEP_W'(1) : cfg_n_sweeps;
            r_slot     <= '0;
            r_round    <= '0;
            r_sweep    <= '0;
            for (int k = 0; k < N; k++) r_pos[k] <= LOG2_N'(k);
          end
        end
        ST_ISSUE: begin
          if (pair_ready) r_slot <= w_last_slot ? '0 : r_slot + LOG2_N_PAIRS'(1);
        end
        ST_WAIT_ROUND: begin
          if (round_done) begin
            r_pos[1] <= r_pos[N-1];
            for (int k = 2; k < N; k++) r_pos[k] <= r_pos[k-1];
            if (!w_last_round) r_round <= r_round + LOG2_N'(1);
          end
        end
        ST_SWEEP_END: begin
          // After N-1 rotations the seating is back at identity, so only the
          // counters need to move on for the next sweep.
          if (!w_finish) begin
            r_sweep <= r_sweep + SWEEP_W'(1);
            r_round <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jacobi_pair_scheduler
// Self-checking bench. The reference describes the schedule as a function of
// the handshake ordinal h: sweep = h/28, round = (h%28)/4, slot = h%4, and the
// seat of position k in round r is 1 + ((k-1-r) mod 7) for k>0, seat 0 fixed.
// Row bases are summed row lengths. Pair timing is tracked at event level.
// -----------------------------------------------------------------------------
module tb_jacobi_pair_scheduler;
  import jacobi_pair_scheduler_pkg::*;

  localparam int NN  = 8;
  localparam int NP  = 4;
  localparam int RPS = NN - 1;
  localparam int PPS = RPS * NP;

  logic       clk = 1'b0;
  logic       rst, start, converged, pair_ready, round_done;
  logic [3:0] cfg_n_sweeps;
  logic       pair_valid, busy, done;
  logic [2:0] pair_p, pair_q, round_idx;
  logic [1:0] pair_slot;
  logic [6:0] addr_pp, addr_qq, addr_pq;
  logic [3:0] sweep_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jacobi_pair_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_n_sweeps(cfg_n_sweeps),
    .converged(converged), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_p(pair_p), .pair_q(pair_q), .pair_slot(pair_slot),
    .addr_pp(addr_pp), .addr_qq(addr_qq), .addr_pq(addr_pq),
    .round_done(round_done), .round_idx(round_idx), .sweep_idx(sweep_idx),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rb(input int i);
    int s = 0;
    for (int r = 0; r < i; r++) s += NN - r;
    return s;
  endfunction

  function automatic int seat(input int r, input int k);
    if (k == 0) return 0;
    return ((k - 1 - r) % RPS + RPS) % RPS + 1;
  endfunction

  task automatic model_pair(input int h, output int p, output int q, output int sl,
                            output int rn, output int sw);
    int a, b;
    sw = h / PPS;
    rn = (h % PPS) / NP;
    sl = h % NP;
    a  = seat(rn, sl);
    b  = seat(rn, NN - 1 - sl);
    p  = (a < b) ? a : b;
    q  = (a < b) ? b : a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(pair_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // mode: 0 ready always, 1 ready one cycle in three, 2 random ready.
  // conv_sw: sweep at whose end converged is raised (-1 never).
  // abort_h: assert rst once h reaches this handshake count (-1 never).
  task automatic run_solve(input int nsw, input int conv_sw, input int mode, input int abort_h);
    int eff, exp_h, h, rd, cyc, rd_delay, p, q, sl, rn, sw, esw;
    bit exp_v, in_end, fin, hs, rdn, wait_m, ended;
    eff   = (nsw == 0) ? 1 : nsw;
    exp_h = (conv_sw >= 0 && conv_sw < eff) ? (conv_sw + 1) * PPS : eff * PPS;
    start = 1'b1;
    cfg_n_sweeps = 4'(nsw);
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    h = 0; rd = 0; cyc = 0; exp_v = 1'b1; in_end = 1'b0; fin = 1'b0; ended = 1'b0;
    rd_delay = $urandom_range(0, 2);
    while (!ended && cyc < 4000) begin
      cyc++;
      chk("pair_valid", int'(pair_valid), int'(exp_v));
      chk("busy", int'(busy), 1);
      chk("done_early", int'(done), 0);
      if (pair_valid && exp_v) begin
        model_pair(h, p, q, sl, rn, sw);
        chk("pair_p", int'(pair_p), p);
        chk("pair_q", int'(pair_q), q);
        chk("pair_slot", int'(pair_slot), sl);
        chk("round_idx", int'(round_idx), rn);
        chk("sweep_idx", int'(sweep_idx), sw);
        chk("addr_pp", int'(addr_pp), rb(p));
        chk("addr_qq", int'(addr_qq), rb(q));
        chk("addr_pq", int'(addr_pq), rb(p) + q - p);
      end
      case (mode)
        0:       pair_ready = 1'b1;
        1:       pair_ready = (cyc % 3 == 0);
        default: pair_ready = 1'($urandom_range(0, 1));
      endcase
      wait_m = !in_end && (h == (rd + 1) * NP);
      rdn = 1'b0;
      if (wait_m) begin
        if (rd_delay == 0) rdn = 1'b1;
        else rd_delay--;
      end else if (!in_end && $urandom_range(0, 7) == 0) begin
        rdn = 1'b1;  // stray pulse while issuing
      end
      round_done   = rdn;
      converged    = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 15) == 0);
      cfg_n_sweeps = 4'($urandom_range(0, 15));
      if (in_end) begin
        esw       = rd / RPS - 1;
        converged = (conv_sw == esw);
        fin       = (conv_sw == esw) || (rd / RPS == eff);
      end
      if (abort_h >= 0 && h == abort_h) rst = 1'b1;
      hs = pair_valid && pair_ready;
      step();
      if (rst) begin
        rst = 1'b0; start = 1'b0; round_done = 1'b0; pair_ready = 1'b0; converged = 1'b0;
        chk_idle("rst");
        chk("rst_round", int'(round_idx), 0);
        chk("rst_sweep", int'(sweep_idx), 0);
        chk("rst_slot", int'(pair_slot), 0);
        for (int i = 0; i < 3; i++) begin
          step();
          chk_idle("post_rst");
        end
        return;
      end
      if (hs) begin
        h++;
        if (h == (rd + 1) * NP) exp_v = 1'b0;
      end
      if (in_end) begin
        in_end = 1'b0;
        if (fin) begin
          chk("done_pulse", int'(done), 1);
          chk("done_busy", int'(busy), 0);
          chk("done_valid", int'(pair_valid), 0);
          chk("done_sweep", int'(sweep_idx), rd / RPS - 1);
          ended = 1'b1;
        end else begin
          exp_v = 1'b1;
        end
      end else if (rdn && wait_m) begin
        rd++;
        rd_delay = $urandom_range(0, 2);
        if (rd % RPS != 0) exp_v = 1'b1;
        else in_end = 1'b1;
      end
    end
    start = 1'b0; round_done = 1'b0; converged = 1'b0;
    if (!ended) chk("timeout", 0, 1);
    chk("handshakes", h, exp_h);
    chk("rounds_consumed", rd, exp_h / NP);
    step();
    chk_idle("after_done");
  endtask

  initial begin
    int p, q, sl, rn, sw;
    rst = 1'b1; start = 1'b0; converged = 1'b0; pair_ready = 1'b0;
    round_done = 1'b0; cfg_n_sweeps = 4'd0;
    step(); step();
    rst = 1'b0;
    step();
    chk_idle("reset");
    chk("reset_round", int'(round_idx), 0);
    chk("reset_sweep", int'(sweep_idx), 0);
    chk("reset_slot", int'(pair_slot), 0);
    round_done = 1'b1;  // stray, DUT idle
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("idle");
    end
    round_done = 1'b0;

    // Pin the reference against hand-computed schedule entries.
    model_pair(0, p, q, sl, rn, sw);
    chk("pin0_p", p, 0); chk("pin0_q", q, 7); chk("pin0_qq", rb(q), 35); chk("pin0_pq", rb(p) + q - p, 7);
    model_pair(1, p, q, sl, rn, sw);
    chk("pin1_pp", rb(p), 8); chk("pin1_qq", rb(q), 33); chk("pin1_pq", rb(p) + q - p, 13);
    model_pair(2, p, q, sl, rn, sw);
    chk("pin2_pp", rb(p), 15); chk("pin2_qq", rb(q), 30); chk("pin2_pq", rb(p) + q - p, 18);
    model_pair(3, p, q, sl, rn, sw);
    chk("pin3_pp", rb(p), 21); chk("pin3_qq", rb(q), 26); chk("pin3_pq", rb(p) + q - p, 22);
    model_pair(4, p, q, sl, rn, sw);
    chk("pin4_p", p, 0); chk("pin4_q", q, 6); chk("pin4_pq", rb(p) + q - p, 6);
    model_pair(5, p, q, sl, rn, sw);
    chk("pin5_p", p, 5); chk("pin5_q", q, 7);
    model_pair(28, p, q, sl, rn, sw);
    chk("pin28_sw", sw, 1); chk("pin28_q", q, 7);

    run_solve(1, -1, 0, -1);
    run_solve(2, -1, 0, -1);
    run_solve(2, -1, 1, -1);
    run_solve(5, 0, 2, -1);
    run_solve(0, -1, 2, -1);
    run_solve(3, -1, 2, 14);

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1; cfg_n_sweeps = 4'd1;
    step();
    rst = 1'b0; start = 1'b0;
    chk_idle("rst_start");
    step();
    chk_idle("rst_start2");

    run_solve(1, -1, 0, -1);
    run_solve(3, 1, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jacobi_pair_scheduler.md
Name: jacobi_pair_scheduler

Overview:
- Sequencing controller for the parallel cyclic Jacobi eigen-solver.
- Generates the round-robin (tournament) ordering of disjoint index pairs (p,q) for an N x N symmetric matrix: N-1 rounds per sweep, N/2 pairs per round.
- Each pair goes to the CORDIC rotation datapath over a valid/ready handshake, together with the packed upper-triangle memory addresses of a_pp, a_qq and a_pq.
- Counts rounds and sweeps; stops after the configured sweep count or on a convergence flag.

Parameters:
- N, JACOBI_N (8), matrix size; even, >= 4.
- LOG2_N, JACOBI_LOG2_N (3), index width.
- N_PAIRS, JACOBI_N_PAIRS (4), pairs per round (N/2).
- LOG2_N_PAIRS, JACOBI_LOG2_N_PAIRS (2), pair-slot index width.
- ADDR_WIDTH, JACOBI_ADDR_WIDTH (7), data memory address width.
- SWEEP_W, 4, sweep counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin solve (pulse)
- cfg_n_sweeps  in  SWEEP_W  max sweeps; sampled on accepted start
- converged  in  1  sampled only at sweep end
- pair_valid  out  1  pair presented
- pair_ready  in  1  datapath accepts pair
- pair_p  out  LOG2_N  lower index (p<q)
- pair_q  out  LOG2_N  upper index
- pair_slot  out  LOG2_N_PAIRS  slot 0..N_PAIRS-1 within round
- addr_pp  out  ADDR_WIDTH  address of a_pp
- addr_qq  out  ADDR_WIDTH  address of a_qq
- addr_pq  out  ADDR_WIDTH  address of a_pq
- round_done  in  1  datapath finished all rotations of current round (pulse)
- round_idx  out  LOG2_N  current round 0..N-2
- sweep_idx  out  SWEEP_W  current sweep
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state IDLE; pair_valid=0, busy=0, done=0, round_idx=0, sweep_idx=0, pair_slot=0, pos[k]=k.
- State machine:
  - IDLE: start=1 -> ISSUE. On that transition, latch cfg_n_sweeps (0 treated as 1), reset pos[k]=k, clear counters, busy=1.
  - ISSUE: pair_valid=1.
    - On pair_valid&pair_ready, pair_slot increments.
    - After slot N_PAIRS-1 is accepted -> WAIT_ROUND with pair_valid=0.
    - Outputs hold stable while pair_ready=0.
  - WAIT_ROUND: on round_done, rotate pos[1..N-1] (new pos[1]=old pos[N-1], new pos[i]=old pos[i-1]); pos[0] stays fixed.
    - If round_idx<N-2: round_idx+1, slot=0 -> ISSUE.
    - Else -> SWEEP_END.
  - SWEEP_END, one cycle:
    - If converged=1 or sweep_idx+1==n_sweeps -> DONE.
    - Else sweep_idx+1, round_idx=0 -> ISSUE. pos is not reset; after N-1 rotations it is back at identity.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Pair of slot k = (pos[k], pos[N-1-k]). pair_p=min, pair_q=max.
- Addresses, combinational from p,q:
  - rb(i) = i*N - i*(i-1)/2 (packed row-major upper triangle, 36 entries for N=8).
  - addr_pp=rb(p), addr_qq=rb(q), addr_pq=rb(p)+(q-p).
- Latency:
  - start accepted at cycle t -> first pair_valid at t+1.
  - round_done at t -> next pair_valid at t+1, or done at t+2 via SWEEP_END.
- Boundary conditions:
  - start while busy: ignored.
  - round_done outside WAIT_ROUND: ignored.
  - rst at any cycle: immediate return to reset values, no done pulse.
  - Simultaneous start and rst: rst wins.

Decomposition:
- Shared package constants: existing JACOBI_N, JACOBI_LOG2_N, JACOBI_N_PAIRS, JACOBI_ADDR_WIDTH, JACOBI_V_OFFSET.
- Add to shared package: a state enum typedef and a pure function jacobi_tri_addr(i,j) for the row-base/offset address, so the V-update logic can reuse it.
- No sub-module; pos-rotation register array is inline.

Test Plan:
- Reset then idle: pair_valid=0, busy=0, done=0, round_idx=0, no activity with start=0.
- start, cfg_n_sweeps=1, pair_ready=1: round 0 pairs are
  - (0,7) pp=0 qq=35 pq=7
  - (1,6) 8/33/13
  - (2,5) 15/30/18
  - (3,4) 21/26/22
  - after round_done, round 1 slot0=(0,6) pq=6 qq=33; slot1=(5,7).
- Full run cfg_n_sweeps=2, converged=0:
  - exactly 56 handshakes, 14 round_done consumed.
  - done pulses once, 2 cycles after final round_done.
  - sweep 1 pairs match sweep 0.
- Backpressure: pair_ready toggling 1-of-3 cycles -> pair_p/q/addr stable while stalled; no slot skipped or duplicated.
- converged=1 at end of sweep 0 with cfg_n_sweeps=5 -> done after 28 pairs, sweep_idx=0.
- rst asserted mid-round 3 -> next cycle all outputs at reset values. A new start then yields round 0 pair (0,7) again. Start pulsed while busy is ignored.
